// File: rtl/kmean_mean_update_sched_if.sv
// Bus between the k-means mean-update scheduler and its cluster stores / shared divider.
// The master side is the scheduler; the slave side is the stores plus the divider.
interface kmean_mean_update_sched_if #(
  parameter int UNIT_W = 8,
  parameter int ACC_W  = 15,
  parameter int CNT_W  = 7,
  parameter int AW     = 4
);
  logic [AW-1:0]       rd_addr;
  logic [3*ACC_W-1:0]  acc_rd;
  logic [CNT_W-1:0]    cnt_rd;
  logic [3*UNIT_W-1:0] mean_rd;
  logic                div_req;
  logic                div_ready;
  logic [ACC_W-1:0]    div_num;
  logic [CNT_W-1:0]    div_den;
  logic                div_valid;
  logic [ACC_W-1:0]    div_quot;
  logic                mean_we;
  logic [3*UNIT_W-1:0] mean_wdata;

  modport master (
    output rd_addr, div_req, div_num, div_den, mean_we, mean_wdata,
    input  acc_rd, cnt_rd, mean_rd, div_ready, div_valid, div_quot
  );
  modport slave (
    input  rd_addr, div_req, div_num, div_den, mean_we, mean_wdata,
    output acc_rd, cnt_rd, mean_rd, div_ready, div_valid, div_quot
  );
endinterface

// File: rtl/kmean_mean_update_sched.sv
// Centroid-update sequencer: per cluster, divides each accumulator axis by the point count on a
// shared divider, writes the saturated mean back and tracks per-axis convergence.
module kmean_mean_update_sched #(
  parameter int UNIT_W = 8,
  parameter int ACC_W  = 15,
  parameter int CNT_W  = 7,
  parameter int KMAX   = 16,
  parameter int AW     = 4,
  parameter int THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW:0]              k_cfg,
  kmean_mean_update_sched_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic [AW:0]              upd_count
);

  typedef enum logic [2:0] {IDLE, RD, CAP, ISS, WT, WR, NXT, FIN} state_t;

  localparam logic [AW:0]     KMAX_V = (AW+1)'(KMAX);
  localparam logic [UNIT_W:0] THR    = (UNIT_W+1)'(THRESH);
  localparam logic [ACC_W-1:0] QMAX  = ACC_W'((1 << UNIT_W) - 1);

  state_t             state, state_nx;
  logic [AW:0]        k_q, cnt, k_clamp;
  logic [AW-1:0]      idx;
  logic [1:0]         axis;
  logic               conv, last;
  logic [ACC_W-1:0]   acc_q [3];
  logic [UNIT_W-1:0]  old_q [3];
  logic [UNIT_W-1:0]  new_q [3];
  logic [CNT_W-1:0]   den_q;
  logic [ACC_W-1:0]   acc_sel;
  logic [UNIT_W-1:0]  old_sel, q_sat;
  logic [UNIT_W:0]    delta;

  function automatic logic [UNIT_W-1:0] sat_unit(input logic [ACC_W-1:0] q);
    if (q >= QMAX) return '1;
    return q[UNIT_W-1:0];
  endfunction

  function automatic logic [UNIT_W:0] abs_diff(input logic [UNIT_W-1:0] a,
                                               input logic [UNIT_W-1:0] b);
    logic signed [UNIT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[UNIT_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  assign k_clamp = (k_cfg > KMAX_V) ? KMAX_V : k_cfg;
  assign last    = ({1'b0, idx} == (k_q - 1'b1));
  assign q_sat   = sat_unit(bus.div_quot);
  assign delta   = abs_diff(q_sat, old_sel);

  always_comb begin
    acc_sel = acc_q[2];
    old_sel = old_q[2];
    case (axis)
      2'd0: begin acc_sel = acc_q[0]; old_sel = old_q[0]; end
      2'd1: begin acc_sel = acc_q[1]; old_sel = old_q[1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (k_clamp == '0) ? FIN : RD;
      RD:   state_nx = CAP;
      CAP:  state_nx = (bus.cnt_rd == '0) ? NXT : ISS;
      ISS:  if (bus.div_ready) state_nx = WT;
      WT:   if (bus.div_valid) state_nx = (axis == 2'd2) ? WR : ISS;
      WR:   state_nx = NXT;
      NXT:  state_nx = last ? FIN : RD;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by state so an asynchronous reset forces every one of them to zero.
  always_comb begin
    bus.rd_addr    = idx;
    bus.div_req    = (state == ISS);
    bus.div_num    = (state == ISS) ? acc_sel : '0;
    bus.div_den    = (state == ISS) ? den_q : '0;
    bus.mean_we    = (state == WR);
    bus.mean_wdata = (state == WR) ? {new_q[0], new_q[1], new_q[2]} : '0;
    busy           = (state != IDLE) && (state != FIN);
    done           = (state == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k_q       <= '0;
      idx       <= '0;
      axis      <= '0;
      conv      <= 1'b0;
      cnt       <= '0;
      converged <= 1'b0;
      upd_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          k_q  <= k_clamp;
          idx  <= '0;
          conv <= 1'b1;
          cnt  <= '0;
          if (k_clamp == '0) begin
            converged <= 1'b1;
            upd_count <= '0;
          end
        end
        CAP: axis <= '0;
        WT: if (bus.div_valid) begin
          if (delta > THR) conv <= 1'b0;
          axis <= (axis == 2'd2) ? 2'd0 : axis + 2'd1;
        end
        WR:  cnt <= cnt + 1'b1;
        NXT: if (last) begin
          converged <= conv;
          upd_count <= cnt;
        end else begin
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Capture stage: store read data lands one cycle after RD; quotients land per axis in WT.
  always_ff @(posedge clk) begin
    if (state == CAP) begin
      acc_q[0] <= bus.acc_rd[3*ACC_W-1 -: ACC_W];
      acc_q[1] <= bus.acc_rd[2*ACC_W-1 -: ACC_W];
      acc_q[2] <= bus.acc_rd[ACC_W-1:0];
      old_q[0] <= bus.mean_rd[3*UNIT_W-1 -: UNIT_W];
      old_q[1] <= bus.mean_rd[2*UNIT_W-1 -: UNIT_W];
      old_q[2] <= bus.mean_rd[UNIT_W-1:0];
      den_q    <= bus.cnt_rd;
    end
    if (state == WT && bus.div_valid) begin
      case (axis)
        2'd0:    new_q[0] <= q_sat;
        2'd1:    new_q[1] <= q_sat;
        default: new_q[2] <= q_sat;
      endcase
    end
  end

endmodule

// File: tb/tb_kmean_mean_update_sched.sv
// Randomized scoreboard bench for kmean_mean_update_sched with store and divider responders.
module tb_kmean_mean_update_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] k_cfg;
  logic       busy, done, converged;
  logic [4:0] upd_count;

  int tests = 0;
  int fails = 0;

  int acc_m  [16][3];
  int cnt_m  [16];
  int mean_m [16][3];

  logic [21:0] div_q  [$];
  logic [27:0] wr_q   [$];
  logic [5:0]  done_q [$];

  int lat = 2;
  bit rand_ready = 0;
  bit stall_mode = 0;
  bit spurious_en = 0;

  kmean_mean_update_sched_if #(.UNIT_W(8), .ACC_W(15), .CNT_W(7), .AW(4)) bus ();

  kmean_mean_update_sched #(.UNIT_W(8), .ACC_W(15), .CNT_W(7), .KMAX(16), .AW(4), .THRESH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .k_cfg(k_cfg), .bus(bus),
    .busy(busy), .done(done), .converged(converged), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cluster stores with one-cycle read latency.
  always @(posedge clk) begin
    bus.acc_rd  <= {15'(acc_m[bus.rd_addr][0]), 15'(acc_m[bus.rd_addr][1]), 15'(acc_m[bus.rd_addr][2])};
    bus.cnt_rd  <= 7'(cnt_m[bus.rd_addr]);
    bus.mean_rd <= {8'(mean_m[bus.rd_addr][0]), 8'(mean_m[bus.rd_addr][1]), 8'(mean_m[bus.rd_addr][2])};
  end

  // Divider: fixed latency, configurable ready policy, optional junk pulses while a request waits.
  logic        div_pend = 1'b0;
  int          div_cd = 0;
  logic [14:0] div_res = '0;
  int          wait_cnt = 0;
  initial begin
    bus.div_valid = 1'b0;
    bus.div_quot  = '0;
    bus.div_ready = 1'b1;
  end
  always @(posedge clk) begin
    bus.div_valid <= 1'b0;
    if (div_pend) begin
      if (div_cd <= 1) begin
        bus.div_valid <= 1'b1;
        bus.div_quot  <= div_res;
        div_pend      <= 1'b0;
      end else begin
        div_cd <= div_cd - 1;
      end
    end else if (spurious_en && bus.div_req && !bus.div_ready) begin
      bus.div_valid <= 1'b1;
      bus.div_quot  <= 15'h7fff;
    end
    if (bus.div_req && bus.div_ready) begin
      div_pend <= 1'b1;
      div_cd   <= lat;
      div_res  <= (bus.div_den == '0) ? 15'h7fff : 15'(bus.div_num / bus.div_den);
    end
    if (stall_mode) begin
      if (bus.div_req && bus.div_ready) begin
        wait_cnt <= 0;
        bus.div_ready <= 1'b0;
      end else if (bus.div_req) begin
        wait_cnt <= wait_cnt + 1;
        bus.div_ready <= (wait_cnt + 1 >= 5);
      end else begin
        wait_cnt <= 0;
        bus.div_ready <= 1'b0;
      end
    end else begin
      bus.div_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake, write or done.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_acc = 1'b0;
    logic [21:0] prev_nd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (bus.div_req) begin
          if (prev_req && !prev_acc) check("div_hold", {bus.div_num, bus.div_den}, prev_nd);
          if (bus.div_ready) begin
            if (div_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL div_unexpected: got %0h expected none", {bus.div_num, bus.div_den});
            end else begin
              check("div_req", {bus.div_num, bus.div_den}, div_q.pop_front());
            end
          end
        end
        prev_req = bus.div_req;
        prev_acc = bus.div_req && bus.div_ready;
        prev_nd  = {bus.div_num, bus.div_den};
        if (bus.mean_we) begin
          if (wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_unexpected: got %0h expected none", {bus.rd_addr, bus.mean_wdata});
          end else begin
            check("mean_write", {bus.rd_addr, bus.mean_wdata}, wr_q.pop_front());
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_unexpected: got %0h expected none", {converged, upd_count});
          end else begin
            check("done_result", {converged, upd_count}, done_q.pop_front());
          end
        end
      end
    end
  end

  // Reference: plain arithmetic over the store contents.
  task automatic model(input int kc);
    int k = (kc > 16) ? 16 : kc;
    bit conv = 1'b1;
    int upd = 0;
    for (int i = 0; i < k; i++) begin
      logic [23:0] nm = '0;
      if (cnt_m[i] == 0) continue;
      for (int a = 0; a < 3; a++) begin
        int q, d;
        div_q.push_back({15'(acc_m[i][a]), 7'(cnt_m[i])});
        q = acc_m[i][a] / cnt_m[i];
        if (q > 255) q = 255;
        d = (q > mean_m[i][a]) ? q - mean_m[i][a] : mean_m[i][a] - q;
        if (d > 2) conv = 1'b0;
        nm[(2-a)*8 +: 8] = 8'(q);
      end
      wr_q.push_back({4'(i), nm});
      upd++;
    end
    done_q.push_back({conv, 5'(upd)});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      cnt_m[i] = 0;
      for (int a = 0; a < 3; a++) begin acc_m[i][a] = 0; mean_m[i][a] = 0; end
    end
  endtask

  task automatic set_cluster(input int i, input int ax, input int ay, input int az, input int c,
                             input int mx, input int my, input int mz);
    acc_m[i][0] = ax; acc_m[i][1] = ay; acc_m[i][2] = az;
    cnt_m[i] = c;
    mean_m[i][0] = mx; mean_m[i][1] = my; mean_m[i][2] = mz;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) begin
      cnt_m[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 100));
      for (int a = 0; a < 3; a++) begin
        int q = $urandom_range(0, 300);
        int o;
        acc_m[i][a] = (cnt_m[i] == 0) ? int'($urandom_range(0, 32767))
                                      : q * cnt_m[i] + int'($urandom_range(0, cnt_m[i] - 1));
        o = ((q > 255) ? 255 : q) + int'($urandom_range(0, 6)) - 3;
        mean_m[i][a] = (o < 0) ? 0 : (o > 255) ? 255 : o;
      end
    end
  endtask

  task automatic run_pass(input int kc);
    int t = 0;
    model(kc);
    @(negedge clk); start = 1'b1; k_cfg = 5'(kc);
    @(negedge clk); start = 1'b0;
    if (kc == 0) check("k0_done_next_cycle", done, 1'b1);
    else         check("busy_after_start", busy, 1'b1);
    while (!done && t < 5000) begin @(negedge clk); t++; end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done within 5000 cycles");
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_on_done_ignored", busy, 1'b0);
    check("queues_drained", 64'(div_q.size() + wr_q.size() + done_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({busy, done, converged, upd_count, bus.div_req, bus.mean_we, bus.rd_addr,
                bus.div_num, bus.div_den, bus.mean_wdata});
  endfunction

  initial begin
    int t;
    reset = 1'b0; start = 1'b0; k_cfg = '0;
    clear_mem();
    #1 reset = 1'b1;
    #1 check("reset_outputs", all_outputs(), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Exact division with one saturating axis; stays converged.
    lat = 2;
    set_cluster(0, 300, 600, 900, 3, 100, 200, 255);
    run_pass(1);

    // Zero-count cluster skipped; second cluster moves by 5 on x.
    clear_mem();
    set_cluster(0, 77, 88, 99, 0, 1, 2, 3);
    set_cluster(1, 40, 40, 40, 4, 5, 10, 13);
    run_pass(2);

    // Quotient 500 saturates to 255.
    clear_mem();
    set_cluster(0, 1000, 20, 30, 2, 255, 10, 15);
    run_pass(1);

    // Long accept stalls with junk quotient pulses while waiting.
    rand_mem();
    stall_mode = 1; spurious_en = 1; lat = 3;
    run_pass(3);
    stall_mode = 0; spurious_en = 0;

    run_pass(0);
    rand_mem();
    lat = 1;
    run_pass(20);

    // Reset while waiting on a quotient, then a clean pass.
    rand_mem();
    set_cluster(0, 5000, 600, 70, 5, 10, 20, 30);
    lat = 4; rand_ready = 0;
    model(4);
    @(negedge clk); start = 1'b1; k_cfg = 5'd4;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!(bus.div_req && bus.div_ready) && t < 200) begin @(negedge clk); t++; end
    if (!(bus.div_req && bus.div_ready)) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no accept expected one within 200 cycles");
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check("reset_in_wt_outputs", all_outputs(), 64'd0);
    div_q.delete(); wr_q.delete(); done_q.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    run_pass(4);

    for (int n = 0; n < 12; n++) begin
      rand_mem();
      lat = $urandom_range(1, 4);
      rand_ready = 1'($urandom_range(0, 1));
      run_pass($urandom_range(1, 16));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
